snake_head_grid: RTL
====================

Name: snake_head_grid

Overview:
Grid-quantised snake head controller, the parametrised successor of the current pixel-stepping head. It moves one cell every STEP_FRAMES frames in a latched direction and rejects 180° reversals against the committed direction. It detects wall collision, or wraps when WRAP=1, and runs a RUN/PAUSE/DEAD state machine. It renders the head cell for the VGA pixel pipeline and emits a one-cycle step strobe for the body/tail segment chain.

Parameters:
CELL, 10, cell edge in pixels
GRID_W, 64, grid width in cells (GRID_W*CELL ≤ 1024)
GRID_H, 48, grid height in cells (GRID_H*CELL ≤ 1024)
STEP_FRAMES, 10, frames per cell step (≥1)
START_X, 1, reset cell column
START_Y, 1, reset cell row
START_DIR, DIR_RIGHT, reset direction
WRAP, 0, 0 = walls kill, 1 = toroidal wrap

Ports:
v_sync  in  1  frame clock; all state on posedge
reset  in  1  synchronous, active-high
up, down, left, right  in  1 each  direction buttons
pause  in  1  freeze movement while high
pixel_row, pixel_column  in  10 each  current VGA pixel
red, green, blue  out  1 each  head pixel colour
head_x, head_y  out  10 each  head top-left pixel (cell*CELL)
cell_x  out  $clog2(GRID_W)  head cell column
cell_y  out  $clog2(GRID_H)  head cell row
current_direction  out  2  committed direction (UP=0, LEFT=1, RIGHT=2, DOWN=3)
step  out  1  one-cycle strobe on each completed move
dead  out  1  high in DEAD

Behaviour:
- Reset has priority over all other inputs. On reset:
  - cell_x=START_X, cell_y=START_Y
  - current_direction = pending_dir = START_DIR
  - frame_cnt=0, state=IDLE, step=0, dead=0
- States: IDLE, RUN, PAUSED, DEAD.
- Button decode, every edge: a press is valid only if exactly one of up/left/right/down is high; multi-press or no press is ignored.
  - A valid press updates pending_dir unless it is the opposite of current_direction (not of pending_dir).
  - The last valid press before a step wins.
  - Presses are accepted in IDLE and RUN, and ignored in PAUSED and DEAD.
- IDLE: no movement. A valid press moves the block to RUN with frame_cnt=0; the press also latches pending_dir.
- RUN:
  - pause=1 → PAUSED, with frame_cnt held. Pause takes precedence over a step due on the same edge.
  - Otherwise frame_cnt increments. When frame_cnt==STEP_FRAMES-1, frame_cnt←0 and the next cell is computed from pending_dir.
  - In bounds: cell updates, current_direction←pending_dir, step=1 for exactly that cycle.
  - Out of bounds, WRAP=0: state←DEAD. Position, direction and step are not updated (step stays 0).
  - Out of bounds, WRAP=1 — x: GRID_W-1 + right → 0; 0 + left → GRID_W-1.
  - Out of bounds, WRAP=1 — y: GRID_H-1 + down → 0; 0 + up → GRID_H-1.
- PAUSED: everything holds. pause=0 → RUN, and counting resumes from the held frame_cnt.
- DEAD: all state held, dead=1. The only exit is reset.
- A button change on the step edge is latched after the step is evaluated, so it applies to the next step.
- Outputs:
  - head_x = cell_x*CELL, head_y = cell_y*CELL (10-bit, zero-extended).
  - All state outputs are registered; step is registered.
- Render (combinational): head_on = pixel_column ∈ [head_x, head_x+CELL-1] && pixel_row ∈ [head_y, head_y+CELL-1].
  - green = head_on & !dead
  - red = head_on & dead
  - blue = 0
  - Comparisons are done in 11 bits to avoid overflow at the right/bottom edge.

Decomposition:
- Package snake_pkg: DIR_UP/LEFT/RIGHT/DOWN 2-bit constants, state encoding, function dir_opposite(), function dir_from_buttons() (returns valid flag + dir).
- Sub-module snake_cell_render: pixel-in-cell compare with CELL parameter; reused later by body segments.

Test Plan:
- Defaults, reset 2 edges then release, right held 1 edge → IDLE→RUN. After 10 edges: cell=(2,1), step pulses once, head_x=20, head_y=10.
- Running right, press left for 1 edge → rejected, direction stays RIGHT. Press down at frame 3 → moves to (x,2) at the next step boundary, current_direction=3.
- Pause asserted on the step-due edge → no move, step=0, frame_cnt held. After pause release → step after the remaining frames only.
- WRAP=0, move up from (1,1) → reaches (1,0), next step → dead=1, cell stays (1,0). Red at pixel (15,5), green 0 there; reset → (1,1), IDLE.
- WRAP=1, cell (63,5) moving right → next step gives cell_x=0, head_x=0, dead=0, step=1.
- up+left pressed together → ignored. Pixel (19,19) lit with head at (1,1); pixel (20,10) not lit.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction/state encodings and button helpers for the snake head
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] dir;
    } press_t;

    // The encoding pairs opposites as bitwise complements (UP/DOWN, LEFT/RIGHT).
    function automatic logic [1:0] dir_opposite(input logic [1:0] dir);
        return ~dir;
    endfunction

    function automatic press_t dir_from_buttons(input logic up, input logic left,
                                                input logic right, input logic down);
        press_t p;
        p.valid = 1'b1;
        p.dir   = DIR_UP;
        case ({up, left, right, down})
            4'b1000: p.dir = DIR_UP;
            4'b0100: p.dir = DIR_LEFT;
            4'b0010: p.dir = DIR_RIGHT;
            4'b0001: p.dir = DIR_DOWN;
            default: p.valid = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/snake_cell_render.sv
// rtl/snake_cell_render.sv - flags pixels inside a CELL x CELL square at a given origin
module snake_cell_render #(
    parameter int CELL = 10
) (
    input  logic [9:0] pixel_row,
    input  logic [9:0] pixel_column,
    input  logic [9:0] origin_x,
    input  logic [9:0] origin_y,
    output logic       on
);
    // One extra bit so origin+CELL-1 cannot wrap at the right/bottom edge.
    logic [10:0] col, row, x0, y0;

    assign col = {1'b0, pixel_column};
    assign row = {1'b0, pixel_row};
    assign x0  = {1'b0, origin_x};
    assign y0  = {1'b0, origin_y};

    assign on = (col >= x0) && (col <= x0 + 11'(CELL - 1)) &&
                (row >= y0) && (row <= y0 + 11'(CELL - 1));
endmodule

// File: rtl/snake_head_grid.sv
// rtl/snake_head_grid.sv - grid-stepped snake head with direction latch, walls/wrap and render
module snake_head_grid
    import snake_pkg::*;
#(
    parameter int         CELL        = 10,
    parameter int         GRID_W      = 64,
    parameter int         GRID_H      = 48,
    parameter int         STEP_FRAMES = 10,
    parameter int         START_X     = 1,
    parameter int         START_Y     = 1,
    parameter logic [1:0] START_DIR   = DIR_RIGHT,
    parameter bit         WRAP        = 1'b0
) (
    input  logic                      v_sync,
    input  logic                      reset,
    input  logic                      up,
    input  logic                      down,
    input  logic                      left,
    input  logic                      right,
    input  logic                      pause,
    input  logic [9:0]                pixel_row,
    input  logic [9:0]                pixel_column,
    output logic                      red,
    output logic                      green,
    output logic                      blue,
    output logic [9:0]                head_x,
    output logic [9:0]                head_y,
    output logic [$clog2(GRID_W)-1:0] cell_x,
    output logic [$clog2(GRID_H)-1:0] cell_y,
    output logic [1:0]                current_direction,
    output logic                      step,
    output logic                      dead
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [1:0]    pending_dir;

    press_t        press;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          oob;
    logic          step_due, advance, move_ok, moving, accept;
    logic [1:0]    commit_dir;
    logic          head_on;

    assign press    = dir_from_buttons(up, left, right, down);
    assign step_due = (frame_cnt == FW'(STEP_FRAMES - 1));
    assign advance  = (state == ST_RUN) && !pause && step_due;
    assign move_ok  = !oob || WRAP;
    assign moving   = advance && move_ok;

    // Reversal check uses the direction in force after this edge's step,
    // so a press on the step edge only ever shapes the following step.
    assign commit_dir = moving ? pending_dir : current_direction;
    assign accept = press.valid && (press.dir != dir_opposite(commit_dir)) &&
                    ((state == ST_IDLE) || ((state == ST_RUN) && !(advance && !move_ok)));

    always_comb begin
        next_x = cell_x;
        next_y = cell_y;
        oob    = 1'b0;
        case (pending_dir)
            DIR_RIGHT: begin
                if (cell_x == XW'(GRID_W - 1)) begin
                    oob    = 1'b1;
                    next_x = '0;
                end else begin
                    next_x = cell_x + XW'(1);
                end
            end
            DIR_LEFT: begin
                if (cell_x == '0) begin
                    oob    = 1'b1;
                    next_x = XW'(GRID_W - 1);
                end else begin
                    next_x = cell_x - XW'(1);
                end
            end
            DIR_DOWN: begin
                if (cell_y == YW'(GRID_H - 1)) begin
                    oob    = 1'b1;
                    next_y = '0;
                end else begin
                    next_y = cell_y + YW'(1);
                end
            end
            default: begin
                if (cell_y == '0) begin
                    oob    = 1'b1;
                    next_y = YW'(GRID_H - 1);
                end else begin
                    next_y = cell_y - YW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge v_sync) begin
        if (reset) begin
            state             <= ST_IDLE;
            frame_cnt         <= '0;
            cell_x            <= XW'(START_X);
            cell_y            <= YW'(START_Y);
            current_direction <= START_DIR;
            pending_dir       <= START_DIR;
            step              <= 1'b0;
            dead              <= 1'b0;
        end else begin
            step <= 1'b0;
            if (accept) begin
                pending_dir <= press.dir;
            end
            case (state)
                ST_IDLE: begin
                    if (press.valid) begin
                        state     <= ST_RUN;
                        frame_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state <= ST_PAUSED;
                    end else if (step_due) begin
                        frame_cnt <= '0;
                        if (move_ok) begin
                            cell_x            <= next_x;
                            cell_y            <= next_y;
                            current_direction <= pending_dir;
                            step              <= 1'b1;
                        end else begin
                            state <= ST_DEAD;
                            dead  <= 1'b1;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state <= ST_RUN;
                    end
                end
                ST_DEAD: begin
                    dead <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign head_x = 10'(int'(cell_x) * CELL);
    assign head_y = 10'(int'(cell_y) * CELL);

    snake_cell_render #(.CELL(CELL)) u_render (
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .origin_x     (head_x),
        .origin_y     (head_y),
        .on           (head_on)
    );

    assign green = head_on & !dead;
    assign red   = head_on & dead;
    assign blue  = 1'b0;
endmodule
